// File: rtl/conv_pkg.sv
// Shared constants, window geometry and FSM state type for the convolution operand feeder.
package conv_pkg;

    localparam int IMG_N       = 4;
    localparam int FLT_N       = 3;
    localparam int NUM_TAPS    = 9;
    localparam int NUM_LANES   = 4;
    localparam int FEED_CYCLES = 12;

    // Window origin (row, col) of each output lane inside the 4x4 image.
    localparam int WIN_ROW [NUM_LANES] = '{0, 0, 1, 1};
    localparam int WIN_COL [NUM_LANES] = '{0, 1, 0, 1};

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DONE
    } feeder_state_t;

    // Maps tap index j = 3i+m to {i, m}; out-of-range taps map to (0,0).
    function automatic logic [3:0] tap_pos(input logic [3:0] j);
        logic [3:0] pos;
        case (j)
            4'd0:    pos = 4'b00_00;
            4'd1:    pos = 4'b00_01;
            4'd2:    pos = 4'b00_10;
            4'd3:    pos = 4'b01_00;
            4'd4:    pos = 4'b01_01;
            4'd5:    pos = 4'b01_10;
            4'd6:    pos = 4'b10_00;
            4'd7:    pos = 4'b10_01;
            4'd8:    pos = 4'b10_10;
            default: pos = 4'b00_00;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/conv_tap_select.sv
// Combinational tap selector for one skewed im2col lane: picks the image/filter pair for feed cycle t.
module conv_tap_select
    import conv_pkg::*;
#(
    parameter int DW   = 8,
    parameter int LANE = 0
) (
    input  logic [16*DW-1:0] snap_a,
    input  logic [9*DW-1:0]  snap_b,
    input  logic [3:0]       t,
    input  logic             active,
    output logic [DW-1:0]    a,
    output logic [DW-1:0]    w,
    output logic             valid,
    output logic             first,
    output logic             last
);

    logic [3:0] j;
    logic [3:0] pos;
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] a_idx;
    logic [3:0] b_idx;

    always_comb begin
        // Lane k runs k cycles behind lane 0, so its tap index is t - k.
        j     = t - 4'(LANE);
        pos   = tap_pos(j);
        row   = pos[3:2];
        col   = pos[1:0];
        a_idx = 4'((WIN_ROW[LANE] + int'(row)) * IMG_N + WIN_COL[LANE] + int'(col));
        b_idx = 4'(int'(row) * FLT_N + int'(col));
        valid = active && (t >= 4'(LANE)) && (j <= 4'(NUM_TAPS - 1));
        first = valid && (j == 4'd0);
        last  = valid && (j == 4'(NUM_TAPS - 1));
        a     = valid ? snap_a[DW*a_idx +: DW] : '0;
        w     = valid ? snap_b[DW*b_idx +: DW] : '0;
    end

endmodule

// File: rtl/conv_operand_feeder.sv
// Snapshots a 4x4 image and 3x3 filter on start and streams four skewed im2col lanes into the MAC array.
module conv_operand_feeder
    import conv_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [16*DW-1:0]          a_flat,
    input  logic [9*DW-1:0]           b_flat,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_LANES*DW-1:0]   lane_a,
    output logic [NUM_LANES*DW-1:0]   lane_w,
    output logic [NUM_LANES-1:0]      lane_valid,
    output logic [NUM_LANES-1:0]      lane_first,
    output logic [NUM_LANES-1:0]      lane_last
);

    feeder_state_t     state;
    logic [3:0]        t;
    logic [16*DW-1:0]  snap_a;
    logic [9*DW-1:0]   snap_b;

    logic [DW-1:0]        sel_a [NUM_LANES];
    logic [DW-1:0]        sel_w [NUM_LANES];
    logic [NUM_LANES-1:0] sel_valid;
    logic [NUM_LANES-1:0] sel_first;
    logic [NUM_LANES-1:0] sel_last;
    logic                 feeding;

    assign feeding = (state == FEED);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        conv_tap_select #(
            .DW   (DW),
            .LANE (k)
        ) u_sel (
            .snap_a (snap_a),
            .snap_b (snap_b),
            .t      (t),
            .active (feeding),
            .a      (sel_a[k]),
            .w      (sel_w[k]),
            .valid  (sel_valid[k]),
            .first  (sel_first[k]),
            .last   (sel_last[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            t          <= '0;
            snap_a     <= '0;
            snap_b     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lane_a     <= '0;
            lane_w     <= '0;
            lane_valid <= '0;
            lane_first <= '0;
            lane_last  <= '0;
        end else begin
            // Output stage: selectors are idle outside FEED, so lanes drain to zero.
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_a[DW*k +: DW] <= sel_a[k];
                lane_w[DW*k +: DW] <= sel_w[k];
            end
            lane_valid <= sel_valid;
            lane_first <= sel_first;
            lane_last  <= sel_last;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= FEED;
                        t      <= '0;
                        snap_a <= a_flat;
                        snap_b <= b_flat;
                        busy   <= 1'b1;
                    end
                end
                FEED: begin
                    if (t == 4'(FEED_CYCLES - 1)) begin
                        state <= DONE;
                        t     <= '0;
                        done  <= 1'b1;
                    end else begin
                        t <= t + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
